// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int BUS_DEFAULT = 32;
    localparam int CNT_W       = $clog2(BUS_DEFAULT);
    localparam int MAX_W       = 64;
    localparam int MAX_IW      = $clog2(MAX_W);

    // Magnitude of the low w bits of v; only negated when signed_op and its MSB is set.
    // The most negative value maps to itself, which reads correctly as unsigned.
    function automatic logic [MAX_W-1:0] abs_if_signed(input logic [MAX_W-1:0] v,
                                                       input int unsigned      w,
                                                       input logic             signed_op);
        logic [MAX_W-1:0]  mask;
        logic [MAX_IW-1:0] msb;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        msb  = MAX_IW'(w - 1);
        if (signed_op && v[msb]) begin
            return (~v + MAX_W'(1)) & mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/sumador_parametrizable.sv
// N-bit adder with a gated b operand: sum = a + (c2 ? b : 0) + cin, carry-out dropped.
module sumador_parametrizable #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c2,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         overflow
);

    logic [N-1:0] b_eff;

    assign b_eff    = c2 ? b : '0;
    assign sum      = a + b_eff + N'(cin);
    assign overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/multiplicador_secuencial.sv
// Iterative MULT/MULTU unit: one shift-add per cycle, sign fix-up, then HI/LO update.
// Optional macro MULT_EARLY_TERM_EN leaves RUN as soon as the remaining multiplier is zero.
module multiplicador_secuencial
    import mult_pkg::*;
#(
    parameter int bus = BUS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_op,
    input  logic [bus-1:0] a,
    input  logic [bus-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [bus-1:0] hi,
    output logic [bus-1:0] lo
);

    localparam int            CW   = $clog2(bus);
    localparam int            W2   = 2 * bus;
    localparam logic [CW-1:0] LAST = CW'(bus - 1);

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [bus-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic [bus-1:0]  hi_q, hi_d;
    logic [bus-1:0]  lo_q, lo_d;

    logic            accept;
    logic            run_exit;
    logic [bus-1:0]  mag_a, mag_b;
    logic [MAX_W-bus-1:0] mag_a_hi_unused, mag_b_hi_unused;

    logic [W2-1:0]   add_a, add_b, add_sum, fix_result;
    logic            add_c2, add_cin, add_ovf_unused;

    assign {mag_a_hi_unused, mag_a} = abs_if_signed(MAX_W'(a), bus, signed_op);
    assign {mag_b_hi_unused, mag_b} = abs_if_signed(MAX_W'(b), bus, signed_op);

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef MULT_EARLY_TERM_EN
    assign run_exit = (count_q == LAST) || (mplier_q[bus-1:1] == '0);
`else
    assign run_exit = (count_q == LAST);
`endif

    // The single adder accumulates in RUN and negates (~acc + 1) in FIX.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        add_a   = acc_q;
        add_b   = mcand_q;
        add_c2  = mplier_q[0];
        add_cin = 1'b0;
        if (state_q == ST_FIX) begin
            add_a   = ~acc_q;
            add_c2  = 1'b0;
            add_cin = 1'b1;
        end
    end

    sumador_parametrizable #(.N(W2)) u_sumador (
        .a        (add_a),
        .b        (add_b),
        .c2       (add_c2),
        .cin      (add_cin),
        .sum      (add_sum),
        .overflow (add_ovf_unused)
    );

    assign fix_result = sign_q ? add_sum : acc_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (run_exit) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_FIX);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        sign_d   = sign_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            sign_d   = signed_op & (a[bus-1] ^ b[bus-1]);
            acc_d    = '0;
            mcand_d  = {{bus{1'b0}}, mag_a};
            mplier_d = mag_b;
            count_d  = '0;
        end else if (state_q == ST_RUN) begin
            acc_d    = add_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end else if (state_q == ST_FIX) begin
            acc_d = fix_result;
            hi_d  = fix_result[W2-1:bus];
            lo_d  = fix_result[bus-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Randomized self-checking bench for multiplicador_secuencial against an arithmetic product model.
module tb_multiplicador_secuencial;

    localparam int BUS = 32;
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            signed_op = 1'b0;
    logic [BUS-1:0]  a = '0;
    logic [BUS-1:0]  b = '0;
    logic            busy, done;
    logic [BUS-1:0]  hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    multiplicador_secuencial #(.bus(BUS)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_prod(input logic [31:0] av, input logic [31:0] bv,
                                               input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            return 64'(sa * sb);
        end
        return {32'd0, av} * {32'd0, bv};
    endfunction

    // Cycles from the start-sampling edge to the done cycle, inclusive of that edge.
    function automatic int exp_latency(input logic [31:0] bv, input logic s);
        logic [31:0] m;
        int top;
        m   = (s && bv[31]) ? (~bv + 32'd1) : bv;
        top = 0;
        for (int i = 0; i < 32; i++) if (m[i]) top = i;
        return EARLY ? top + 3 : BUS + 2;
    endfunction

    // Issues one multiply and waits (bounded) for done; reports observations only.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                          output int lat, output logic [31:0] h, output logic [31:0] l,
                          output int busy_err, output logic done_next);
        a = av; b = bv; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busy_err = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_err++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_err++;
        h = hi; l = lo;
        @(posedge clk); #1;
        done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'h1234_5678};
        logic [31:0] tb_ [6] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd6, 32'd0};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eh [6] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] el [6] = '{32'hF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFD6, 32'h0};
        int lat, berr; logic [31:0] h, l; logic dn;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_[i], ts[i], lat, h, l, berr, dn);
            n_cmp++; if (h !== eh[i]) begin n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, h, eh[i]); end
            n_cmp++; if (l !== el[i]) begin n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, l, el[i]); end
            n_cmp++; if (lat !== exp_latency(tb_[i], ts[i])) begin
                n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_latency(tb_[i], ts[i])); end
            n_cmp++; if (berr !== 0) begin n_bad++; $display("FAIL dir%0d_busy got %0d bad cycles want 0", i, berr); end
            n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse got %b want 0", i, dn); end
        end
    endtask

    task automatic test_random();
        int lat, berr; logic [31:0] h, l, av, bv; logic s, dn; logic [63:0] p;
        for (int i = 0; i < 24; i++) begin
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = $urandom;
                1:       bv = $urandom_range(0, 255);
                2:       bv = 32'hFFFF_FFFF - $urandom_range(0, 255);
                default: bv = 32'h1 << $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            p = model_prod(av, bv, s);
            run_op(av, bv, s, lat, h, l, berr, dn);
            n_cmp++; if ({h, l} !== p) begin
                n_bad++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got %h%h want %h", i, av, bv, s, h, l, p); end
            n_cmp++; if (lat !== exp_latency(bv, s)) begin
                n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_latency(bv, s)); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] av, bv, h, l; logic [63:0] p; int ndone, lat;
        av = $urandom; bv = 32'h8000_0000 | $urandom;
        p = model_prod(av, bv, 1'b0);
        a = av; b = bv; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ndone = 0; lat = 0; h = '0; l = '0;
        for (int n = 1; n <= 80; n++) begin
            if (n == 5 || n == 20) begin start = 1'b1; a = $urandom; b = $urandom; signed_op = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin ndone++; lat = n + 1; h = hi; l = lo; end
        end
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_cmp++; if (lat !== BUS + 2) begin n_bad++; $display("FAIL ignore_latency got %0d want %0d", lat, BUS + 2); end
        n_cmp++; if ({h, l} !== p) begin n_bad++; $display("FAIL ignore_product got %h%h want %h", h, l, p); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, h1, l1; logic s2; int lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom; s2 = 1'b1;
        a = a1; b = b1; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        h1 = hi; l1 = lo;
        n_cmp++; if ({h1, l1} !== model_prod(a1, b1, 1'b0)) begin
            n_bad++; $display("FAIL b2b_first got %h%h want %h", h1, l1, model_prod(a1, b1, 1'b0)); end
        a = a2; b = b2; signed_op = s2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== exp_latency(b2, s2)) begin
            n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_latency(b2, s2)); end
        n_cmp++; if ({hi, lo} !== model_prod(a2, b2, s2)) begin
            n_bad++; $display("FAIL b2b_second got %h%h want %h", hi, lo, model_prod(a2, b2, s2)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, berr, ndone; logic [31:0] h, l; logic dn;
        run_op(32'd3, 32'd5, 1'b0, lat, h, l, berr, dn);
        n_cmp++; if (lo !== 32'hF) begin n_bad++; $display("FAIL rstmid_pre_lo got %h want f", lo); end
        a = $urandom; b = 32'h8000_0001; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", lo); end
        rst = 1'b0; ndone = 0;
        repeat (60) begin @(posedge clk); #1; if (done === 1'b1) ndone++; end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d pulses want 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
